// File: rtl/secuenciador_sumas.sv
// Command sequencer for a shared adder and register bank.
// Commands (dst, a, b) are queued in a small FIFO; on start they are
// executed back to back, one per cycle, as R[dst] = R[a] + R[b].
module secuenciador_sumas #(
  parameter int NUMREG = 8,
  parameter int DEPTH  = 4,
  localparam int INDEX_SIZE = $clog2(NUMREG),
  localparam int CNT_SIZE   = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inicio_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [INDEX_SIZE-1:0] cmd_dst_i,
  input  logic [INDEX_SIZE-1:0] cmd_a_i,
  input  logic [INDEX_SIZE-1:0] cmd_b_i,
  output logic [INDEX_SIZE-1:0] A_o,
  output logic [INDEX_SIZE-1:0] B_o,
  output logic [INDEX_SIZE-1:0] id_o,
  output logic                  we_o,
  output logic                  ocupado_o,
  output logic                  fin_o,
  output logic [CNT_SIZE-1:0]   cuenta_o,
  output logic [7:0]            hechas_o
);

  localparam int PTR_SIZE = $clog2(DEPTH);

  typedef enum logic [1:0] {ESPERA, EJECUTA, FIN} estado_t;

  estado_t estado, estado_sig;

  logic [INDEX_SIZE-1:0] mem_dst [DEPTH];
  logic [INDEX_SIZE-1:0] mem_a   [DEPTH];
  logic [INDEX_SIZE-1:0] mem_b   [DEPTH];
  logic [PTR_SIZE-1:0]   rd_ptr, wr_ptr;
  logic [CNT_SIZE-1:0]   cuenta;
  logic [7:0]            hechas;
  logic                  push, pop;

  // Handshake: full FIFO refuses pushes even when a pop happens this cycle.
  assign cmd_ready_o = (cuenta < CNT_SIZE'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (estado == EJECUTA);
  assign cuenta_o    = cuenta;
  assign hechas_o    = hechas;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_i) estado <= ESPERA;
    else       estado <= estado_sig;
  end

  // Next-state logic and bank-facing outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    estado_sig = estado;
    we_o       = 1'b0;
    A_o        = '0;
    B_o        = '0;
    id_o       = '0;
    ocupado_o  = 1'b0;
    fin_o      = 1'b0;
    unique case (estado)
      ESPERA: begin
        if (inicio_i) estado_sig = (cuenta != '0) ? EJECUTA : FIN;
      end
      EJECUTA: begin
        we_o      = 1'b1;
        ocupado_o = 1'b1;
        A_o       = mem_a[rd_ptr];
        B_o       = mem_b[rd_ptr];
        id_o      = mem_dst[rd_ptr];
        // Last entry leaves unless a new command arrives in the same cycle.
        if (cuenta == CNT_SIZE'(1) && !push) estado_sig = FIN;
      end
      FIN: begin
        fin_o      = 1'b1;
        estado_sig = ESPERA;
      end
      default: estado_sig = ESPERA;
    endcase
  end

  // FIFO storage; written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; pointers and count define validity.
    if (push) begin
      mem_dst[wr_ptr] <= cmd_dst_i;
      mem_a[wr_ptr]   <= cmd_a_i;
      mem_b[wr_ptr]   <= cmd_b_i;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cuenta <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cuenta <= cuenta + CNT_SIZE'(1);
        2'b01:   cuenta <= cuenta - CNT_SIZE'(1);
        default: cuenta <= cuenta;
      endcase
    end
  end

  // Writes issued since the last accepted start, saturating at 255.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               hechas <= '0;
    else if (estado == ESPERA && inicio_i)   hechas <= '0;
    else if (pop && hechas != 8'hFF)         hechas <= hechas + 8'd1;
  end

endmodule

// File: doc/secuenciador_sumas.md
SECUENCIADOR_SUMAS -- requirements
Module: secuenciador_sumas

Interface
REQ-001 The block SHALL have parameter NUMREG, default 8, giving the number of registers in the register bank.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the command FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have localparam INDEX_SIZE = $clog2(NUMREG) and localparam CNT_SIZE = $clog2(DEPTH+1).
REQ-004 The block SHALL have these ports, with clock and reset first:
- clk_i  input  1  single clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-high reset
- inicio_i  input  1  start execution of the queued commands
- cmd_valid_i  input  1  a command is presented
- cmd_ready_o  output  1  the block can accept a command
- cmd_dst_i  input  INDEX_SIZE  destination register id
- cmd_a_i  input  INDEX_SIZE  source register A id
- cmd_b_i  input  INDEX_SIZE  source register B id
- A_o  output  INDEX_SIZE  register bank read port A id
- B_o  output  INDEX_SIZE  register bank read port B id
- id_o  output  INDEX_SIZE  register bank write id
- we_o  output  1  register bank write enable
- ocupado_o  output  1  high while executing
- fin_o  output  1  one-cycle completion pulse
- cuenta_o  output  CNT_SIZE  number of FIFO entries
- hechas_o  output  8  number of writes issued since the last accepted start

Function
REQ-005 The block SHALL sequence the shared adder and register bank so that each command performs R[dst] = R[a] + R[b], one command per cycle.
REQ-006 A command SHALL be accepted (pushed) on a rising edge where cmd_valid_i and cmd_ready_o are both high.
REQ-007 cmd_ready_o SHALL equal (cuenta_o < DEPTH) in every state; the block SHALL NOT accept a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-008 The FIFO SHALL be first-in first-out with wrap-around read and write pointers; pushes SHALL be accepted in every state, including during execution.
REQ-009 The FSM SHALL have three states: ESPERA, EJECUTA and FIN.
REQ-010 In ESPERA, when inicio_i = 1 and cuenta_o > 0, the FSM SHALL go to EJECUTA and clear hechas_o to 0.
REQ-011 In ESPERA, when inicio_i = 1 and cuenta_o = 0, the FSM SHALL go to FIN and clear hechas_o to 0.
REQ-012 inicio_i SHALL be ignored in EJECUTA and in FIN.
REQ-013 In EJECUTA, we_o SHALL be 1, and A_o, B_o and id_o SHALL be driven combinationally from the FIFO head (a, b and dst fields respectively).
REQ-014 In EJECUTA, the head SHALL be popped on each rising edge, and hechas_o SHALL increment by one, saturating at 255.
REQ-015 In EJECUTA, when the pop leaves the FIFO empty (cuenta_o = 1 with no simultaneous push), the FSM SHALL go to FIN; a simultaneous push SHALL keep it in EJECUTA.
REQ-016 In FIN, fin_o SHALL be 1 for exactly one cycle and the FSM SHALL then return to ESPERA.
REQ-017 In ESPERA and FIN, we_o SHALL be 0 and A_o, B_o and id_o SHALL be 0.
REQ-018 ocupado_o SHALL be 1 exactly when the state is EJECUTA.
REQ-019 Each write lands on the clock edge ending its EJECUTA cycle, so a command reading the previous command's destination SHALL see the updated value; the block SHALL NOT insert stalls.
REQ-020 cuenta_o SHALL update as +1 on push only, -1 on pop only, and be unchanged on simultaneous push and pop.

Reset
REQ-021 While rst_i = 1, the block SHALL asynchronously force:
- state to ESPERA
- FIFO pointers and cuenta_o to 0
- hechas_o to 0
- fin_o and we_o to 0
- cmd_ready_o to 1
- A_o, B_o and id_o to 0
REQ-022 Reset asserted during EJECUTA SHALL abort execution immediately, discard all queued commands and issue no further writes.
REQ-023 Reset SHALL NOT clear the register bank contents; that is owned by the bank.

Verification
REQ-024 Push (dst=1, a=0, b=0), (dst=2, a=1, b=1), (dst=3, a=2, b=1), then pulse inicio_i -> we_o high for 3 consecutive cycles with id_o = 1, 2, 3; fin_o pulses on the 4th cycle; hechas_o = 3; cuenta_o = 0.
REQ-025 Push DEPTH = 4 commands -> cmd_ready_o = 0 and cuenta_o = 4; a 5th cmd_valid_i is not accepted; after inicio_i, exactly 4 writes occur.
REQ-026 Pulse inicio_i with an empty FIFO -> no write occurs; fin_o is high on the next cycle only; hechas_o = 0.
REQ-027 With 2 commands queued, start, then push a 3rd command in the first EJECUTA cycle -> 3 contiguous writes followed by a single fin_o pulse.
REQ-028 Assert rst_i in the 2nd EJECUTA cycle of a 4-command run -> we_o drops immediately; cuenta_o = 0; no fin_o pulse; a subsequent inicio_i produces fin_o with hechas_o = 0.
REQ-029 Run 260 single-command starts without a reset between them, then queue and run 260 commands in one run with continuous pushing -> hechas_o saturates at 255.
